// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } lsu_state_e;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_data_align.sv
// rtl/load_data_align.sv - byte-lane shift and sign/zero extension of a load word
module load_data_align
    import lsu_pkg::*;
(
    input  logic [31:0] RDATA,
    input  logic [1:0]  OFFSET,
    input  logic [2:0]  FUNCT3,
    output logic [31:0] DATA
);

    logic [31:0] shifted;

    assign shifted = RDATA >> {OFFSET, 3'b000};

    always_comb begin
        DATA = shifted;
        case (FUNCT3)
            F3_LB:   DATA = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  DATA = {24'd0, shifted[7:0]};
            F3_LH:   DATA = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  DATA = {16'd0, shifted[15:0]};
            default: DATA = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store memory stage
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    input  logic        MEM_READY,
    input  logic [31:0] MEM_RDATA,
    output logic        BUSY,
    output logic        WB_VALID,
    output logic [4:0]  WB_RD,
    output logic [31:0] WB_DATA,
    output logic        DONE,
    output logic        FAULT,
    output logic [1:0]  FAULT_CAUSE
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_n;
    logic [CW-1:0] cnt_q;
    logic        is_load_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] wb_data_q;
    logic [1:0]  cause_q;

    logic        is_load, is_store, f3_ok, misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic        latch, accept, set_cause;
    logic [1:0]  cause_n;
    logic [31:0] aligned;

    assign is_load  = (OPCODE == OPCODE_LOAD);
    assign is_store = (OPCODE == OPCODE_STORE);
    assign f3_ok    = funct3_legal(is_store, FUNCT3);
    // FUNCT3[1:0] encodes size for both loads and stores (00 byte, 01 half, 10 word)
    assign misaligned = ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                        ((FUNCT3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'd0;
        if (is_store) begin
            case (FUNCT3)
                F3_SB: begin
                    be_n    = 4'b0001 << ADDR[1:0];
                    wdata_n = {4{STORE_DATA[7:0]}};
                end
                F3_SH: begin
                    be_n    = 4'b0011 << ADDR[1:0];
                    wdata_n = {2{STORE_DATA[15:0]}};
                end
                default: wdata_n = STORE_DATA;
            endcase
        end
    end

    always_comb begin
        state_n   = state_q;
        latch     = 1'b0;
        accept    = 1'b0;
        set_cause = 1'b0;
        cause_n   = CAUSE_NONE;
        case (state_q)
            ST_IDLE: begin
                if (START && (is_load || is_store)) begin
                    latch = 1'b1;
                    if (!f3_ok) begin
                        state_n   = ST_ERR;
                        set_cause = 1'b1;
                        cause_n   = CAUSE_FUNCT3;
                    end else if (misaligned) begin
                        state_n   = ST_ERR;
                        set_cause = 1'b1;
                        cause_n   = CAUSE_MISALIGNED;
                    end else begin
                        state_n = ST_REQ;
                        accept  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (MEM_READY) begin
                    state_n = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_n   = ST_ERR;
                    set_cause = 1'b1;
                    cause_n   = CAUSE_TIMEOUT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    load_data_align u_align (
        .RDATA  (MEM_RDATA),
        .OFFSET (off_q),
        .FUNCT3 (f3_q),
        .DATA   (aligned)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            rd_q      <= 5'd0;
            wb_data_q <= 32'd0;
            cause_q   <= CAUSE_NONE;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 32'd0;
            MEM_WDATA <= 32'd0;
            MEM_BE    <= 4'b0000;
        end else begin
            state_q <= state_n;
            if (set_cause)
                cause_q <= cause_n;
            if (latch) begin
                is_load_q <= is_load;
                off_q     <= ADDR[1:0];
                f3_q      <= FUNCT3;
                rd_q      <= RD;
            end
            if (accept) begin
                MEM_REQ   <= 1'b1;
                MEM_WE    <= is_store;
                MEM_ADDR  <= {ADDR[31:2], 2'b00};
                MEM_WDATA <= wdata_n;
                MEM_BE    <= be_n;
            end
            if (state_q == ST_REQ) begin
                if (state_n != ST_REQ) begin
                    MEM_REQ <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (MEM_READY && is_load_q)
                    wb_data_q <= aligned;
            end
        end
    end

    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = (state_q == ST_RESP);
    assign WB_VALID    = (state_q == ST_RESP) && is_load_q;
    assign FAULT       = (state_q == ST_ERR);
    assign WB_RD       = rd_q;
    assign WB_DATA     = wb_data_q;
    assign FAULT_CAUSE = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [6:0]  OPCODE = '0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] ADDR = '0;
    logic [31:0] STORE_DATA = '0;
    logic [4:0]  RD = '0;
    logic        MEM_REQ, MEM_WE;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic        MEM_READY = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        BUSY, WB_VALID, DONE, FAULT;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic [1:0]  FAULT_CAUSE;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int fault_cnt = 0;
    int req_cnt = 0;
    int wb_cnt = 0;
    logic [36:0] exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
        .ADDR(ADDR), .STORE_DATA(STORE_DATA), .RD(RD),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_BE(MEM_BE), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .DONE(DONE), .FAULT(FAULT), .FAULT_CAUSE(FAULT_CAUSE)
    );

    always #5 CLK = ~CLK;

    // Advance one cycle, sample 1ns after the edge, and retire any writeback against the scoreboard
    task automatic tick();
        logic [36:0] e;
        @(posedge CLK);
        #1;
        if (WB_VALID) begin
            wb_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected got rd=%0d data=%h, none expected", WB_RD, WB_DATA);
            end else begin
                e = exp_q.pop_front();
                if ({WB_RD, WB_DATA} !== e) begin
                    miscompares++;
                    $display("FAIL wb_data got rd=%0d data=%h expected rd=%0d data=%h",
                             WB_RD, WB_DATA, e[36:32], e[31:0]);
                end
            end
        end
        if (DONE) done_cnt++;
        if (FAULT) fault_cnt++;
        if (MEM_REQ) req_cnt++;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        START = 1'b1; OPCODE = op; FUNCT3 = f3; ADDR = a; STORE_DATA = sd; RD = rd;
        tick();
        START = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        MEM_READY = 1'b1; MEM_RDATA = rdata;
        tick();
        MEM_READY = 1'b0; MEM_RDATA = 32'h0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        MEM_READY = 1'b1;
        tick(); tick();
        MEM_READY = 1'b0;
        vectors++;
        if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, BUSY, WB_VALID, WB_RD, WB_DATA,
             DONE, FAULT, FAULT_CAUSE} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got req=%b addr=%h be=%b busy=%b cause=%b expected all zero",
                     MEM_REQ, MEM_ADDR, MEM_BE, BUSY, FAULT_CAUSE);
        end
        RST_N = 1'b1;
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        vectors++;
        if (BUSY !== 1'b0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL idle_ready_ignored got busy=%b done_cnt=%0d expected 0/0", BUSY, done_cnt);
        end
    endtask

    task automatic test_lw();
        exp_q.push_back({5'd3, 32'hDEADBEEF});
        issue(OP_LOAD, 3'b010, 32'h0000_1000, 32'h0, 5'd3);
        vectors++;
        if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE} !== {1'b1, 1'b0, 32'h0000_1000, 4'b1111}) begin
            miscompares++;
            $display("FAIL lw_request got req=%b we=%b addr=%h be=%b expected 1/0/00001000/1111",
                     MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE);
        end
        respond(32'hDEADBEEF);
        vectors++;
        if ({WB_VALID, DONE, MEM_REQ} !== 3'b110) begin
            miscompares++;
            $display("FAIL lw_t2 got wb=%b done=%b req=%b expected 1/1/0", WB_VALID, DONE, MEM_REQ);
        end
        tick();
        vectors++;
        if ({WB_VALID, DONE, BUSY} !== 3'b000) begin
            miscompares++;
            $display("FAIL lw_pulse_width got wb=%b done=%b busy=%b expected 0/0/0", WB_VALID, DONE, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        logic [31:0] adrs[6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1004};
        logic [31:0] exps[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012,
                                 32'h00003456, 32'h80123456};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({5'(i), exps[i]});
            issue(OP_LOAD, f3s[i], adrs[i], 32'h0, 5'(i));
            respond(32'h80123456);
            vectors++;
            if (WB_VALID !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d] got wb=%b expected 1", i, WB_VALID);
            end
            tick();
        end
    endtask

    task automatic test_store();
        int d0, w0;
        logic [2:0]  f3s[3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] adrs[3] = '{32'h2002, 32'h2001, 32'h2004};
        logic [31:0] sds[3] = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D};
        logic [3:0]  bes[3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wds[3] = '{32'hABCDABCD, 32'h78787878, 32'hCAFEF00D};
        logic [31:0] mas[3] = '{32'h2000, 32'h2000, 32'h2004};
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt; w0 = wb_cnt;
            issue(OP_STORE, f3s[i], adrs[i], sds[i], 5'd9);
            vectors++;
            if ({MEM_REQ, MEM_WE, MEM_BE, MEM_WDATA, MEM_ADDR} !== {1'b1, 1'b1, bes[i], wds[i], mas[i]}) begin
                miscompares++;
                $display("FAIL store_lanes[%0d] got req=%b we=%b be=%b wdata=%h addr=%h expected 1/1/%b/%h/%h",
                         i, MEM_REQ, MEM_WE, MEM_BE, MEM_WDATA, MEM_ADDR, bes[i], wds[i], mas[i]);
            end
            respond(32'h0);
            tick();
            vectors++;
            if (done_cnt != d0 + 1 || wb_cnt != w0) begin
                miscompares++;
                $display("FAIL store_done[%0d] got done+%0d wb+%0d expected done+1 wb+0",
                         i, done_cnt - d0, wb_cnt - w0);
            end
        end
    endtask

    task automatic test_faults();
        int r0;
        logic [6:0]  ops [4] = '{OP_LOAD, OP_STORE, OP_LOAD, OP_STORE};
        logic [2:0]  f3s [4] = '{3'b010, 3'b100, 3'b011, 3'b100};
        logic [31:0] adrs[4] = '{32'h1001, 32'h1000, 32'h1000, 32'h1001};
        logic [1:0]  cs  [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            r0 = req_cnt;
            issue(ops[i], f3s[i], adrs[i], 32'h0, 5'd1);
            vectors++;
            if ({FAULT, FAULT_CAUSE, MEM_REQ} !== {1'b1, cs[i], 1'b0}) begin
                miscompares++;
                $display("FAIL fault[%0d] got fault=%b cause=%b req=%b expected 1/%b/0",
                         i, FAULT, FAULT_CAUSE, MEM_REQ, cs[i]);
            end
            tick();
            vectors++;
            if ({FAULT, BUSY, FAULT_CAUSE} !== {1'b0, 1'b0, cs[i]} || req_cnt != r0) begin
                miscompares++;
                $display("FAIL fault_after[%0d] got fault=%b busy=%b cause=%b reqs=%0d expected 0/0/%b/0",
                         i, FAULT, BUSY, FAULT_CAUSE, req_cnt - r0, cs[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(OP_LOAD, 3'b010, 32'h5000, 32'h0, 5'd4);
        for (int i = 0; i < 20 && MEM_REQ; i++) begin
            n++;
            tick();
        end
        vectors++;
        if (n != 4 || {FAULT, FAULT_CAUSE, MEM_REQ} !== 4'b1110) begin
            miscompares++;
            $display("FAIL timeout got req_cycles=%0d fault=%b cause=%b req=%b expected 4/1/11/0",
                     n, FAULT, FAULT_CAUSE, MEM_REQ);
        end
        tick();
        vectors++;
        if ({BUSY, FAULT} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_idle got busy=%b fault=%b expected 0/0", BUSY, FAULT);
        end
    endtask

    task automatic test_reset_mid();
        int d0, w0, f0;
        issue(OP_LOAD, 3'b010, 32'h6000, 32'h0, 5'd5);
        RST_N = 1'b0;
        tick();
        vectors++;
        if ({MEM_REQ, BUSY, FAULT_CAUSE} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid got req=%b busy=%b cause=%b expected 0/0/00", MEM_REQ, BUSY, FAULT_CAUSE);
        end
        RST_N = 1'b1;
        d0 = done_cnt; w0 = wb_cnt; f0 = fault_cnt;
        respond(32'h55555555);
        tick();
        vectors++;
        if (done_cnt != d0 || wb_cnt != w0 || fault_cnt != f0) begin
            miscompares++;
            $display("FAIL reset_abort got done+%0d wb+%0d fault+%0d expected none",
                     done_cnt - d0, wb_cnt - w0, fault_cnt - f0);
        end
    endtask

    task automatic test_ignored_start();
        exp_q.push_back({5'd7, 32'h11223344});
        issue(OP_LOAD, 3'b010, 32'h3000, 32'h0, 5'd7);
        START = 1'b1; OPCODE = OP_STORE; FUNCT3 = 3'b010; ADDR = 32'h4444_0000; RD = 5'd8;
        tick(); tick();
        START = 1'b0;
        vectors++;
        if ({MEM_REQ, MEM_WE, MEM_ADDR} !== {1'b1, 1'b0, 32'h3000}) begin
            miscompares++;
            $display("FAIL busy_start got req=%b we=%b addr=%h expected 1/0/00003000", MEM_REQ, MEM_WE, MEM_ADDR);
        end
        respond(32'h11223344);
        tick();
        issue(OP_ALU, 3'b010, 32'h3000, 32'h0, 5'd2);
        tick();
        vectors++;
        if ({BUSY, MEM_REQ} !== 2'b00) begin
            miscompares++;
            $display("FAIL non_mem_opcode got busy=%b req=%b expected 0/0", BUSY, MEM_REQ);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_store();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_ignored_start();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wb_missing got %0d pending writebacks expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
